// File: rtl/perf_pkg.sv
// Shared types and helpers for the loop performance sampler: FSM state,
// the per-run record layout and a saturating counter step.
package perf_pkg;

    localparam int DEF_CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PUSH = 2'd2
    } perf_state_t;

    typedef struct packed {
        logic [DEF_CNT_W-1:0] cycles;
        logic [DEF_CNT_W-1:0] iters;
        logic [DEF_CNT_W-1:0] stalls;
    } perf_rec_t;

    // Step value by one when en is set, holding once max_value is reached.
    function automatic logic [DEF_CNT_W-1:0] sat_inc(
        input logic [DEF_CNT_W-1:0] value,
        input logic [DEF_CNT_W-1:0] max_value,
        input logic                 en
    );
        logic [DEF_CNT_W-1:0] result;
        result = value;
        if (en && (value != max_value)) begin
            result = value + DEF_CNT_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/perf_rec_fifo.sv
// First-word-fall-through record FIFO; the head entry is visible on rd_data
// whenever the FIFO is not empty, and reads as zero when it is empty.
module perf_rec_fifo
    import perf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      wr_en,
    input  perf_rec_t wr_data,
    input  logic      rd_en,
    output perf_rec_t rd_data,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    perf_rec_t        mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty = (count_reg == '0);

    // A write into a full FIFO is accepted when the head leaves in the same cycle.
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);

    assign rd_data = empty ? '0 : mem_reg[rd_ptr_reg];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/loop_perf_sampler.sv
// Per-run profiler for a pipelined HLS loop: counts cycles, completed
// iterations and stall cycles for each start-to-done run and queues a record.
module loop_perf_sampler
    import perf_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_done,
    input  logic             iter_end_en,
    input  logic             stall,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [CNT_W-1:0] rec_cycles,
    output logic [CNT_W-1:0] rec_iters,
    output logic [CNT_W-1:0] rec_stalls,
    output logic             busy,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             dropped
);

    localparam logic [DEF_CNT_W-1:0] CNT_MAX = DEF_CNT_W'({CNT_W{1'b1}});

    perf_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cycles_reg, cycles_next;
    logic [CNT_W-1:0] iters_reg, iters_next;
    logic [CNT_W-1:0] stalls_reg, stalls_next;
    logic [CNT_W-1:0] drop_cnt_reg;
    logic             dropped_reg;
    logic             push_req;
    logic             inc_iter;
    logic             pop;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    perf_rec_t        wr_rec;
    perf_rec_t        rd_rec;

    // Counters are narrower than the record fields when CNT_W < DEF_CNT_W.
    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] value, input logic en);
        return CNT_W'(sat_inc(DEF_CNT_W'(value), CNT_MAX, en));
    endfunction

    assign inc_iter = iter_end_en && !stall;

    always_comb begin
        state_next  = state_reg;
        cycles_next = cycles_reg;
        iters_next  = iters_reg;
        stalls_next = stalls_reg;
        push_req    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ap_start) begin
                    state_next  = RUN;
                    cycles_next = CNT_W'(1);
                    iters_next  = CNT_W'(inc_iter);
                    stalls_next = CNT_W'(stall);
                end
            end
            RUN: begin
                cycles_next = bump(cycles_reg, 1'b1);
                iters_next  = bump(iters_reg, inc_iter);
                stalls_next = bump(stalls_reg, stall);
                if (ap_done) begin
                    state_next = PUSH;
                end
            end
            PUSH: begin
                push_req = 1'b1;
                // A start seen while pushing begins the next run immediately.
                if (ap_start) begin
                    state_next  = RUN;
                    cycles_next = CNT_W'(1);
                    iters_next  = CNT_W'(inc_iter);
                    stalls_next = CNT_W'(stall);
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            cycles_reg   <= '0;
            iters_reg    <= '0;
            stalls_reg   <= '0;
            drop_cnt_reg <= '0;
            dropped_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cycles_reg   <= cycles_next;
            iters_reg    <= iters_next;
            stalls_reg   <= stalls_next;
            drop_cnt_reg <= bump(drop_cnt_reg, drop);
            dropped_reg  <= dropped_reg || drop;
        end
    end

    assign pop  = rec_valid && rec_ready;
    assign drop = push_req && fifo_full && !pop;

    always_comb begin
        wr_rec        = '0;
        wr_rec.cycles = DEF_CNT_W'(cycles_reg);
        wr_rec.iters  = DEF_CNT_W'(iters_reg);
        wr_rec.stalls = DEF_CNT_W'(stalls_reg);
    end

    perf_rec_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .wr_en  (push_req),
        .wr_data(wr_rec),
        .rd_en  (rec_ready),
        .rd_data(rd_rec),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign rec_valid  = !fifo_empty;
    assign rec_cycles = rd_rec.cycles[CNT_W-1:0];
    assign rec_iters  = rd_rec.iters[CNT_W-1:0];
    assign rec_stalls = rd_rec.stalls[CNT_W-1:0];
    assign busy       = (state_reg != IDLE);
    assign drop_cnt   = drop_cnt_reg;
    assign dropped    = dropped_reg;

endmodule

// File: tb/tb_loop_perf_sampler.sv
// Bench for loop_perf_sampler: a 32-bit and a 4-bit instance share stimulus and
// are compared every cycle against a run-level model with unbounded counts.
module tb_loop_perf_sampler;

    localparam int DEPTH = 4;
    localparam int WA    = 32;
    localparam int WB    = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset       = 1'b1;
    logic ap_start    = 1'b0;
    logic ap_done     = 1'b0;
    logic iter_end_en = 1'b0;
    logic stall       = 1'b0;
    logic rec_ready   = 1'b0;

    logic          a_rec_valid, a_busy, a_dropped;
    logic [WA-1:0] a_rec_cycles, a_rec_iters, a_rec_stalls, a_drop_cnt;
    logic          b_rec_valid, b_busy, b_dropped;
    logic [WB-1:0] b_rec_cycles, b_rec_iters, b_rec_stalls, b_drop_cnt;

    loop_perf_sampler #(.CNT_W(WA), .FIFO_DEPTH(DEPTH)) dut_a (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_done(ap_done),
        .iter_end_en(iter_end_en), .stall(stall), .rec_valid(a_rec_valid),
        .rec_ready(rec_ready), .rec_cycles(a_rec_cycles), .rec_iters(a_rec_iters),
        .rec_stalls(a_rec_stalls), .busy(a_busy), .drop_cnt(a_drop_cnt), .dropped(a_dropped)
    );

    loop_perf_sampler #(.CNT_W(WB), .FIFO_DEPTH(DEPTH)) dut_b (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_done(ap_done),
        .iter_end_en(iter_end_en), .stall(stall), .rec_valid(b_rec_valid),
        .rec_ready(rec_ready), .rec_cycles(b_rec_cycles), .rec_iters(b_rec_iters),
        .rec_stalls(b_rec_stalls), .busy(b_busy), .drop_cnt(b_drop_cnt), .dropped(b_dropped)
    );

    typedef struct {
        longint cycles;
        longint iters;
        longint stalls;
    } rec_m_t;

    rec_m_t q[$];
    longint m_cyc = 0, m_it = 0, m_st = 0, m_drops = 0;
    bit     m_in_run = 0, m_push_pending = 0;
    int     chk_cnt = 0, pass_cnt = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        chk_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Advance the model across the coming clock edge using the applied inputs.
    task automatic model_edge();
        bit pop;
        bit was_push;
        if (reset) begin
            q.delete();
            m_in_run = 0; m_push_pending = 0;
            m_cyc = 0; m_it = 0; m_st = 0; m_drops = 0;
        end else begin
            pop      = (q.size() > 0) && rec_ready;
            was_push = m_push_pending;
            if (pop) void'(q.pop_front());
            if (was_push) begin
                if (q.size() < DEPTH) q.push_back('{m_cyc, m_it, m_st});
                else m_drops++;
            end
            m_push_pending = 0;
            if (m_in_run) begin
                m_cyc++;
                m_it += longint'(iter_end_en && !stall);
                m_st += longint'(stall);
                if (ap_done) begin
                    m_in_run = 0;
                    m_push_pending = 1;
                end
            end else if (ap_start) begin
                m_in_run = 1;
                m_cyc = 1;
                m_it = longint'(iter_end_en && !stall);
                m_st = longint'(stall);
            end
        end
    endtask

    task automatic check_dut();
        rec_m_t h;
        bit     hv;
        bit     bz;
        hv = (q.size() > 0);
        h  = '{0, 0, 0};
        if (hv) h = q[0];
        bz = m_in_run || m_push_pending;
        check_val("a_valid",  longint'(a_rec_valid),  longint'(hv));
        check_val("a_cycles", longint'(a_rec_cycles), sat(h.cycles, WA));
        check_val("a_iters",  longint'(a_rec_iters),  sat(h.iters, WA));
        check_val("a_stalls", longint'(a_rec_stalls), sat(h.stalls, WA));
        check_val("a_busy",   longint'(a_busy),       longint'(bz));
        check_val("a_drops",  longint'(a_drop_cnt),   sat(m_drops, WA));
        check_val("a_dropped", longint'(a_dropped),   longint'(m_drops > 0));
        check_val("b_valid",  longint'(b_rec_valid),  longint'(hv));
        check_val("b_cycles", longint'(b_rec_cycles), sat(h.cycles, WB));
        check_val("b_iters",  longint'(b_rec_iters),  sat(h.iters, WB));
        check_val("b_stalls", longint'(b_rec_stalls), sat(h.stalls, WB));
        check_val("b_busy",   longint'(b_busy),       longint'(bz));
        check_val("b_drops",  longint'(b_drop_cnt),   sat(m_drops, WB));
        check_val("b_dropped", longint'(b_dropped),   longint'(m_drops > 0));
    endtask

    task automatic step(input bit s, input bit d, input bit ie, input bit sl,
                        input bit rdy, input bit rs);
        ap_start = s; ap_done = d; iter_end_en = ie; stall = sl;
        rec_ready = rdy; reset = rs;
        model_edge();
        @(posedge clock);
        #1;
        check_dut();
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 0, 0, rdy, 0);
    endtask

    // Start at c=0, done at c=done_c, iter_end_en and stall over inclusive ranges.
    task automatic run_seq(input int done_c, input int ie_lo, input int ie_hi,
                           input int st_lo, input int st_hi, input bit rdy);
        for (int c = 0; c <= done_c; c++) begin
            step(c == 0, c == done_c, (c >= ie_lo) && (c <= ie_hi),
                 (c >= st_lo) && (c <= st_hi), rdy, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);

        // Nominal run
        run_seq(12, 2, 11, -1, -1, 0);
        check_val("nom_valid_push", longint'(a_rec_valid), 0);
        idle(0);
        check_val("nom_valid", longint'(a_rec_valid), 1);
        check_val("nom_cycles", longint'(a_rec_cycles), 13);
        check_val("nom_iters", longint'(a_rec_iters), 10);
        check_val("nom_stalls", longint'(a_rec_stalls), 0);
        idle(1);

        // Stalled iterations are not counted
        run_seq(15, 2, 14, 5, 7, 0);
        idle(0);
        check_val("stl_cycles", longint'(a_rec_cycles), 16);
        check_val("stl_iters", longint'(a_rec_iters), 10);
        check_val("stl_stalls", longint'(a_rec_stalls), 3);
        idle(1);

        // Saturation in the 4-bit instance
        run_seq(20, 1, 20, -1, -1, 0);
        idle(0);
        check_val("sat_b_cycles", longint'(b_rec_cycles), 15);
        check_val("sat_b_iters", longint'(b_rec_iters), 15);
        check_val("sat_a_cycles", longint'(a_rec_cycles), 21);
        check_val("sat_a_iters", longint'(a_rec_iters), 20);
        idle(1);

        // Overflow: five runs into a four-deep FIFO
        for (int r = 0; r < 5; r++) run_seq(3 + r, 1, 2 + r, -1, -1, 0);
        idle(0);
        idle(0);
        check_val("ovf_drop_cnt", longint'(a_drop_cnt), 1);
        check_val("ovf_dropped", longint'(a_dropped), 1);
        for (int k = 0; k < 4; k++) begin
            check_val("ovf_order", longint'(a_rec_cycles), longint'(4 + k));
            idle(1);
        end
        check_val("ovf_empty", longint'(a_rec_valid), 0);

        // Back-to-back runs: start held in the PUSH cycle
        for (int c = 0; c <= 9; c++) begin
            step((c == 0) || (c == 6), (c == 5) || (c == 9), 0, 0, 0, 0);
            check_val("b2b_busy", longint'(a_busy), 1);
        end
        idle(0);
        check_val("b2b_busy_fall", longint'(a_busy), 0);
        check_val("b2b_first", longint'(a_rec_cycles), 6);
        idle(1);
        check_val("b2b_second", longint'(a_rec_cycles), 4);
        idle(1);

        // Reset in the middle of a run with a record queued
        run_seq(3, 1, 2, -1, -1, 0);
        idle(0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        check_val("rst_busy", longint'(a_busy), 0);
        check_val("rst_valid", longint'(a_rec_valid), 0);
        check_val("rst_drop_cnt", longint'(a_drop_cnt), 0);
        check_val("rst_dropped", longint'(a_dropped), 0);
        run_seq(6, 1, 3, 2, 2, 0);
        idle(0);
        check_val("rst_fresh_cycles", longint'(a_rec_cycles), 7);
        check_val("rst_fresh_iters", longint'(a_rec_iters), 2);
        check_val("rst_fresh_stalls", longint'(a_rec_stalls), 1);
        idle(1);

        // Randomized traffic with a slow consumer and occasional resets
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 599) == 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
